// File: rtl/game_ctrl_fsm.sv
// Snake game controller: START/PLAYING/PAUSE/RESPAWN/OVER sequencing, level latch,
// per-level move_tick pacing, lives and saturating score. All outputs are registered.
module game_ctrl_fsm #(
  parameter int N_BTN       = 4,
  parameter int N_LEVEL     = 3,
  parameter int LIVES       = 3,
  parameter int TICK_BASE   = 8,
  parameter int RESPAWN_CYC = 4,
  parameter int OVER_HOLD   = 4,
  parameter int SCORE_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BTN-1:0]             btn,
  input  logic                         pause_btn,
  input  logic [N_LEVEL-1:0]           sw,
  input  logic                         hit_wall,
  input  logic                         hit_self,
  input  logic                         food_eaten,
  output logic [2:0]                   game_state,
  output logic [$clog2(N_LEVEL+1)-1:0] level,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [SCORE_W-1:0]           score,
  output logic                         move_tick,
  output logic                         respawn
);

  localparam int LVL_W  = $clog2(N_LEVEL+1);
  localparam int LIV_W  = $clog2(LIVES+1);
  localparam int TICK_W = $clog2(TICK_BASE+1);
  localparam int RESP_W = $clog2(RESPAWN_CYC+1);
  localparam int HOLD_W = (OVER_HOLD < 1) ? 1 : $clog2(OVER_HOLD+1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_RESP  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LIV_W-1:0]    lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [RESP_W-1:0]   resp_cnt_q, resp_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                move_tick_q, move_tick_d;
  logic                respawn_q, respawn_d;
  logic [N_BTN-1:0]    btn_q;
  logic                pause_q;

  logic [N_BTN-1:0]    btn_rise;
  logic                pause_rise;
  logic [LVL_W-1:0]    sw_level;
  logic [TICK_W-1:0]   tick_last;

  assign btn_rise   = btn & ~btn_q;
  assign pause_rise = pause_btn & ~pause_q;

  // Highest set switch wins; lower bits are overwritten by higher ones.
  always_comb begin
    sw_level = '0;
    for (int i = 0; i < N_LEVEL; i++) begin
      if (sw[i]) sw_level = LVL_W'(i + 1);
    end
  end

  // Period halves with each level: P = TICK_BASE >> (level-1); counter wraps at P-1.
  assign tick_last = TICK_W'((32'(TICK_BASE) >> (32'(level_q) - 32'd1)) - 32'd1);

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    score_d     = score_q;
    tick_d      = tick_q;
    resp_cnt_d  = resp_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    move_tick_d = 1'b0;
    respawn_d   = 1'b0;
    case (state_q)
      S_START: begin
        if ((|sw) && (|btn_rise)) begin
          state_d = S_PLAY;
          level_d = sw_level;
          lives_d = LIV_W'(LIVES);
          score_d = '0;
          tick_d  = '0;
        end
      end
      S_PLAY: begin
        if (hit_wall || hit_self) begin
          if (lives_q > LIV_W'(1)) begin
            lives_d    = lives_q - LIV_W'(1);
            state_d    = S_RESP;
            respawn_d  = 1'b1;
            resp_cnt_d = '0;
          end else begin
            lives_d    = '0;
            state_d    = S_OVER;
            hold_cnt_d = '0;
          end
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end else begin
          if (food_eaten && (score_q != {SCORE_W{1'b1}})) score_d = score_q + SCORE_W'(1);
          if (tick_q == tick_last) begin
            tick_d      = '0;
            move_tick_d = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (pause_rise || (|btn_rise)) state_d = S_PLAY;
      end
      S_RESP: begin
        if (resp_cnt_q == RESP_W'(RESPAWN_CYC - 1)) begin
          state_d = S_PLAY;
          tick_d  = '0;
        end else begin
          resp_cnt_d = resp_cnt_q + RESP_W'(1);
        end
      end
      S_OVER: begin
        if (hold_cnt_q != HOLD_W'(OVER_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else if ((|btn_rise) || pause_rise) begin
          state_d = S_START;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_START;
      level_q     <= '0;
      lives_q     <= LIV_W'(LIVES);
      score_q     <= '0;
      tick_q      <= '0;
      resp_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      move_tick_q <= 1'b0;
      respawn_q   <= 1'b0;
      btn_q       <= '0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      tick_q      <= tick_d;
      resp_cnt_q  <= resp_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      move_tick_q <= move_tick_d;
      respawn_q   <= respawn_d;
      btn_q       <= btn;
      pause_q     <= pause_btn;
    end
  end

  assign game_state = state_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign move_tick  = move_tick_q;
  assign respawn    = respawn_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm: expected values queued with each stimulus step,
// popped and compared against the DUT after the step.
module tb_game_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] btn;
  logic       pause_btn;
  logic [2:0] sw;
  logic       hit_wall, hit_self, food_eaten;

  logic [2:0] game_state, game_state_s;
  logic [1:0] level, level_s, lives, lives_s;
  logic [7:0] score;
  logic [1:0] score_s;
  logic       move_tick, move_tick_s, respawn, respawn_s;

  game_ctrl_fsm dut (
    .clk(clk), .reset(reset), .btn(btn), .pause_btn(pause_btn), .sw(sw),
    .hit_wall(hit_wall), .hit_self(hit_self), .food_eaten(food_eaten),
    .game_state(game_state), .level(level), .lives(lives), .score(score),
    .move_tick(move_tick), .respawn(respawn)
  );

  // Narrow-score copy for saturation checks; driven identically.
  game_ctrl_fsm #(.SCORE_W(2)) dut_s (
    .clk(clk), .reset(reset), .btn(btn), .pause_btn(pause_btn), .sw(sw),
    .hit_wall(hit_wall), .hit_self(hit_self), .food_eaten(food_eaten),
    .game_state(game_state_s), .level(level_s), .lives(lives_s), .score(score_s),
    .move_tick(move_tick_s), .respawn(respawn_s)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, output int ticks, output int first);
    ticks = 0;
    first = 0;
    for (int c = 1; c <= n; c++) begin
      step(1);
      if (move_tick === 1'b1) begin
        ticks++;
        if (first == 0) first = c;
      end
    end
  endtask

  initial begin
    int ticks, first;
    reset = 1'b0; btn = '0; pause_btn = 1'b0; sw = '0;
    hit_wall = 1'b0; hit_self = 1'b0; food_eaten = 1'b0;

    // Reset values
    expect_v(0); expect_v(0); expect_v(3); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    step(2);
    chk("rst_state", 32'(game_state)); chk("rst_level", 32'(level)); chk("rst_lives", 32'(lives));
    chk("rst_score", 32'(score)); chk("rst_tick", 32'(move_tick)); chk("rst_respawn", 32'(respawn));
    chk("rst_score_s", 32'(score_s));
    reset = 1'b1;

    // Level 2 start, move_tick every 4 cycles
    sw = 3'b010; btn = 4'b0010;
    expect_v(1); expect_v(2); expect_v(3); expect_v(0);
    step(1);
    chk("l2_state", 32'(game_state)); chk("l2_level", 32'(level));
    chk("l2_lives", 32'(lives)); chk("l2_score", 32'(score));
    btn = '0;
    expect_v(4); expect_v(4);
    run_cycles(16, ticks, first);
    chk("l2_ticks", 32'(ticks)); chk("l2_first", 32'(first));

    // Async reset in PLAYING
    expect_v(0); expect_v(0);
    reset = 1'b0; #2;
    chk("arst_play_state", 32'(game_state)); chk("arst_play_level", 32'(level));
    @(posedge clk); #1; reset = 1'b1;

    // Level 1, food scoring and saturation
    sw = 3'b001; btn = 4'b0001;
    expect_v(1); expect_v(1);
    step(1);
    chk("l1_state", 32'(game_state)); chk("l1_level", 32'(level));
    btn = '0;
    repeat (5) begin
      food_eaten = 1'b1; step(1); food_eaten = 1'b0; step(1);
    end
    expect_v(5); expect_v(3);
    chk("food_score", 32'(score)); chk("food_score_sat", 32'(score_s));

    // Pause at tick counter 5 (counter is 2 after 10 cycles)
    step(3);
    pause_btn = 1'b1;
    expect_v(2);
    step(1);
    chk("pause_state", 32'(game_state));
    pause_btn = 1'b0;
    hit_wall = 1'b1; food_eaten = 1'b1;
    expect_v(2); expect_v(3); expect_v(5);
    step(1);
    chk("pause_hit_state", 32'(game_state)); chk("pause_hit_lives", 32'(lives));
    chk("pause_food_score", 32'(score));
    hit_wall = 1'b0; food_eaten = 1'b0;
    expect_v(0); expect_v(2);
    run_cycles(20, ticks, first);
    chk("pause_no_tick", 32'(ticks)); chk("pause_hold_state", 32'(game_state));
    btn = 4'b0100;
    expect_v(1);
    step(1);
    chk("resume_state", 32'(game_state));
    btn = '0;
    expect_v(1); expect_v(3);
    run_cycles(8, ticks, first);
    chk("resume_ticks", 32'(ticks)); chk("resume_first", 32'(first));

    // First hit: respawn sequence
    hit_wall = 1'b1;
    expect_v(3); expect_v(1); expect_v(2);
    step(1);
    chk("hit1_state", 32'(game_state)); chk("hit1_respawn", 32'(respawn)); chk("hit1_lives", 32'(lives));
    hit_wall = 1'b0; food_eaten = 1'b1;
    expect_v(0); expect_v(3);
    step(1);
    chk("resp_pulse_end", 32'(respawn)); chk("resp_state2", 32'(game_state));
    expect_v(3);
    step(2);
    chk("resp_state4", 32'(game_state));
    expect_v(1); expect_v(5);
    step(1);
    chk("resp_exit_state", 32'(game_state)); chk("resp_food_ignored", 32'(score));
    food_eaten = 1'b0;
    expect_v(1); expect_v(8);
    run_cycles(8, ticks, first);
    chk("resp_ticks", 32'(ticks)); chk("resp_first", 32'(first));

    // Second hit
    hit_self = 1'b1;
    expect_v(1); expect_v(1);
    step(1);
    chk("hit2_lives", 32'(lives)); chk("hit2_respawn", 32'(respawn));
    hit_self = 1'b0;
    expect_v(1);
    step(4);
    chk("hit2_back_play", 32'(game_state));

    // Third hit with simultaneous food
    hit_wall = 1'b1; food_eaten = 1'b1;
    expect_v(4); expect_v(0); expect_v(5); expect_v(3);
    step(1);
    chk("over_state", 32'(game_state)); chk("over_lives", 32'(lives));
    chk("over_score", 32'(score)); chk("over_score_s", 32'(score_s));
    hit_wall = 1'b0; food_eaten = 1'b0;
    btn = 4'b1000; step(1); btn = '0; step(2); btn = 4'b1000;
    expect_v(4);
    step(1);
    chk("over_hold_ignore", 32'(game_state));
    expect_v(4);
    step(1);
    chk("over_held_no_edge", 32'(game_state));
    btn = '0; step(1); btn = 4'b0010;
    expect_v(0); expect_v(1); expect_v(0); expect_v(5);
    step(1);
    chk("over_exit_state", 32'(game_state)); chk("start_keep_level", 32'(level));
    chk("start_keep_lives", 32'(lives)); chk("start_keep_score", 32'(score));
    expect_v(0);
    step(1);
    chk("start_held_btn", 32'(game_state));
    btn = '0;

    // sw=0 with button edges stays in START
    sw = 3'b000;
    repeat (3) begin
      btn = 4'b0001; step(1); btn = '0; step(1);
    end
    expect_v(0);
    chk("sw0_stay_start", 32'(game_state));

    // Level 3, then async reset in PAUSE
    sw = 3'b100; btn = 4'b0001;
    expect_v(1); expect_v(3); expect_v(3); expect_v(0);
    step(1);
    chk("l3_state", 32'(game_state)); chk("l3_level", 32'(level));
    chk("l3_lives", 32'(lives)); chk("l3_score", 32'(score));
    btn = '0;
    expect_v(3); expect_v(2);
    run_cycles(6, ticks, first);
    chk("l3_ticks", 32'(ticks)); chk("l3_first", 32'(first));
    pause_btn = 1'b1;
    expect_v(2);
    step(1);
    chk("l3_pause", 32'(game_state));
    expect_v(0); expect_v(0); expect_v(3); expect_v(0); expect_v(0); expect_v(0);
    reset = 1'b0; #2;
    chk("arst_pause_state", 32'(game_state)); chk("arst_pause_level", 32'(level));
    chk("arst_pause_lives", 32'(lives)); chk("arst_pause_score", 32'(score));
    chk("arst_pause_tick", 32'(move_tick)); chk("arst_pause_respawn", 32'(respawn));
    @(posedge clk); #1; pause_btn = 1'b0; reset = 1'b1;

    // Reach OVER with a held hit, then async reset in OVER
    btn = 4'b0001;
    expect_v(1);
    step(1);
    chk("l3b_state", 32'(game_state));
    btn = '0; hit_wall = 1'b1;
    expect_v(4); expect_v(0);
    step(11);
    chk("held_hit_over", 32'(game_state)); chk("held_hit_lives", 32'(lives));
    hit_wall = 1'b0;
    sw = 3'b001; btn = 4'b0001;
    expect_v(0); expect_v(3); expect_v(0); expect_v(0);
    reset = 1'b0; #2;
    chk("arst_over_state", 32'(game_state)); chk("arst_over_lives", 32'(lives));
    chk("arst_over_level", 32'(level)); chk("arst_over_respawn", 32'(respawn));
    @(posedge clk); #1;
    expect_v(0);
    chk("in_reset_state", 32'(game_state));
    reset = 1'b1;

    // Button held through reset release gives exactly one edge
    expect_v(1); expect_v(1);
    step(1);
    chk("held_rst_state", 32'(game_state)); chk("held_rst_level", 32'(level));
    expect_v(1);
    step(2);
    chk("held_rst_stay", 32'(game_state));
    btn = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
